addsub32_seq: RTL and testbench
===============================

Name: addsub32_seq

Overview:
- Multi-cycle sequencer that performs 32-bit add/subtract by time-sharing one external combinational 16-bit Brent-Kung adder (A, B, cin -> sum, cout).
- The low half is computed first; its carry is registered and fed into the high half. Subtraction is A + ~B + 1.
- Sits beside the EX stage as the 32-bit arithmetic engine when only a 16-bit adder instance is available. The caller uses a start/busy/done handshake.

Parameters:
- HALF_W, 16, width of the shared adder; operand/result width is 2*HALF_W.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- op  input  1  0 = add, 1 = subtract (A - B).
- a  input  2*HALF_W  operand A.
- b  input  2*HALF_W  operand B.
- adder_a  output  HALF_W  to shared adder A input.
- adder_b  output  HALF_W  to shared adder B input (already inverted for sub).
- adder_cin  output  1  to shared adder carry-in.
- adder_sum  input  HALF_W  from shared adder (combinational).
- adder_cout  input  1  from shared adder.
- busy  output  1  high in LO and HI.
- done  output  1  one-cycle pulse; result/flags valid.
- result  output  2*HALF_W  registered result; held until next DONE.
- cout  output  1  carry out of bit 2*HALF_W-1 (for sub: 1 = no borrow).
- ovf  output  1  signed overflow.

Behaviour:
- States: IDLE, LO, HI, DONE.
- Reset (rst=1 at edge): state=IDLE, busy=0, done=0, result=0, cout=0, ovf=0, internal carry/operand registers=0. Takes priority over everything, including mid-operation; any in-flight operation is abandoned and no done is produced.
- IDLE, start=1: latch a, b_eff (b if op=0, ~b if op=1), op -> LO. With start=0: stay in IDLE.
- LO: adder_a=a_q[HALF_W-1:0], adder_b=b_eff_q[HALF_W-1:0], adder_cin=op_q. At the edge: capture adder_sum into result low half, capture adder_cout into carry_q -> HI.
- HI: adder_a=a_q high half, adder_b=b_eff_q high half, adder_cin=carry_q. At the edge: capture adder_sum into result high half, cout<=adder_cout, ovf <= (a_q[MSB]==b_eff_q[MSB]) && (adder_sum[MSB]!=a_q[MSB]) -> DONE.
- DONE: done=1 for this cycle only.
  - start=1: accept a new operation exactly as in IDLE -> LO (back-to-back, 3 cycles per op).
  - start=0: -> IDLE.
- start in LO/HI is ignored (not queued); a, b, op may change freely after acceptance.
- Adder ports in IDLE and DONE: adder_a=0, adder_b=0, adder_cin=0.
- Latency: start accepted at edge t0; done high during the cycle after edge t2 (t2..t3).
- result/cout/ovf change only at the HI->DONE edge (the low half updates at LO->HI) and hold afterwards.
- Arithmetic is modulo 2^(2*HALF_W); no exceptions raised.

Optional Feature:
- Macro ADDSUB_SAT_EN.
- Defined: at the HI->DONE edge, if the computed overflow is 1, result is replaced by the signed saturation value: 0x7FFF_FFFF if a_q[MSB]=0, 0x8000_0000 if a_q[MSB]=1. ovf still reports 1; cout is unchanged.
- Undefined: result is always the wrapped sum; no saturation logic is present.

Test Plan:
- Add with carry across halves: op=0, a=0x0000FFFF, b=0x00000001 -> done after 3 cycles; result=0x00010000, cout=0, ovf=0. adder_cin=1 observed in HI.
- Subtract borrow: op=1, a=0x00000000, b=0x00000001 -> result=0xFFFFFFFF, cout=0, ovf=0. Also op=1, a=5, b=3 -> result=2, cout=1.
- Signed overflow: op=0, a=0x7FFFFFFF, b=0x00000001 -> result=0x80000000, ovf=1. With ADDSUB_SAT_EN: result=0x7FFFFFFF, ovf=1.
- Back-to-back: start held high with two operand sets (1+2, then 10-4) -> done pulses 3 cycles apart with results 3 and 6. start pulses during LO/HI are ignored.
- Reset mid-op: assert rst during HI -> next cycle state IDLE, busy=0, done=0, result=0, and no done pulse follows.

Source files
------------

// File: rtl/addsub32_seq.sv
// addsub32_seq: 32-bit add/subtract sequencer. It time-shares one external
// combinational HALF_W-bit adder over two cycles. The low half is computed
// first, then the high half using the registered low-half carry.
// Subtraction is A + ~B + 1.
//
// Optional feature: define ADDSUB_SAT_EN to saturate the result on signed
// overflow (0x7FFF_FFFF for positive A, 0x8000_0000 for negative A).
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   start, op, a, b     request handshake; op 0 = add, 1 = subtract
//   adder_a/b/cin       drive the shared adder (b already inverted for sub)
//   adder_sum/cout      combinational return from the shared adder
//   busy                high while the LO and HI halves are in progress
//   done                one-cycle pulse when result/cout/ovf are valid
//   result, cout, ovf   registered result, carry out of the MSB, signed overflow
module addsub32_seq #(
    parameter int HALF_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                op,
    input  logic [2*HALF_W-1:0] a,
    input  logic [2*HALF_W-1:0] b,
    output logic [HALF_W-1:0]   adder_a,
    output logic [HALF_W-1:0]   adder_b,
    output logic                adder_cin,
    input  logic [HALF_W-1:0]   adder_sum,
    input  logic                adder_cout,
    output logic                busy,
    output logic                done,
    output logic [2*HALF_W-1:0] result,
    output logic                cout,
    output logic                ovf
);

    localparam int W = 2 * HALF_W;

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_eff_q, b_eff_d;
    logic           op_q, op_d;
    logic           carry_q, carry_d;
    logic [W-1:0]   result_q, result_d;
    logic           cout_q, cout_d;
    logic           ovf_q, ovf_d;

    // Signed overflow of the full-width sum. It is only meaningful while the
    // high half is on the adder. Both operands have the same sign, but the
    // sum sign differs from it.
    logic ovf_hi;
    assign ovf_hi = (a_q[W-1] == b_eff_q[W-1]) && (adder_sum[HALF_W-1] != a_q[W-1]);

    always_comb begin
        // NOTE: every signal gets a default first, so no path can leave one
        // unassigned and infer a latch.
        state_d   = state_q;
        a_d       = a_q;
        b_eff_d   = b_eff_q;
        op_d      = op_q;
        carry_d   = carry_q;
        result_d  = result_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        adder_a   = '0;
        adder_b   = '0;
        adder_cin = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_eff_d = op ? ~b : b;
                    op_d    = op;
                    state_d = LO;
                end else begin
                    state_d = IDLE;
                end
            end
            LO: begin
                adder_a   = a_q[HALF_W-1:0];
                adder_b   = b_eff_q[HALF_W-1:0];
                adder_cin = op_q;  // the "+1" of two's-complement subtraction
                result_d[HALF_W-1:0] = adder_sum;
                carry_d   = adder_cout;
                state_d   = HI;
            end
            HI: begin
                adder_a   = a_q[W-1:HALF_W];
                adder_b   = b_eff_q[W-1:HALF_W];
                adder_cin = carry_q;
                result_d[W-1:HALF_W] = adder_sum;
                cout_d    = adder_cout;
                ovf_d     = ovf_hi;
`ifdef ADDSUB_SAT_EN
                if (ovf_hi) begin
                    result_d = a_q[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
                end
`endif
                state_d   = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_eff_q  <= '0;
            op_q     <= 1'b0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_eff_q  <= b_eff_d;
            op_q     <= op_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy   = (state_q == LO) || (state_q == HI);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_addsub32_seq.sv
// Directed testbench for addsub32_seq. It models the shared 16-bit adder
// combinationally and checks handshake timing, arithmetic and reset
// behaviour against hand-computed values.
module tb_addsub32_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        op;
    logic [31:0] a, b;
    logic [15:0] adder_a, adder_b, adder_sum;
    logic        adder_cin, adder_cout;
    logic        busy, done, cout, ovf;
    logic [31:0] result;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Shared adder: a plain 17-bit sum stands in for the Brent-Kung instance.
    assign {adder_cout, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b} + {16'b0, adder_cin};

    addsub32_seq #(.HALF_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op         (op),
        .a          (a),
        .b          (b),
        .adder_a    (adder_a),
        .adder_b    (adder_b),
        .adder_cin  (adder_cin),
        .adder_sum  (adder_sum),
        .adder_cout (adder_cout),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .cout       (cout),
        .ovf        (ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: pass the rising edge, then sample and drive at the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
        step(); step();
        rst = 1'b0;
        check("rst_busy",   32'(busy),   32'h0);
        check("rst_done",   32'(done),   32'h0);
        check("rst_result", result,      32'h0);
        check("rst_cout",   32'(cout),   32'h0);
        check("rst_ovf",    32'(ovf),    32'h0);
        check("rst_adder_a", 32'(adder_a), 32'h0);

        // Stay idle with start low
        step();
        check("idle_busy", 32'(busy), 32'h0);

        // 0x0000FFFF + 1: carry crosses halves
        start = 1'b1; op = 1'b0; a = 32'h0000_FFFF; b = 32'h0000_0001;
        step();                       // LO
        start = 1'b0; a = '0; b = '0; // operands may change after acceptance
        check("add_lo_busy", 32'(busy),      32'h1);
        check("add_lo_a",    32'(adder_a),   32'h0000_FFFF);
        check("add_lo_b",    32'(adder_b),   32'h0000_0001);
        check("add_lo_cin",  32'(adder_cin), 32'h0);
        step();                       // HI
        check("add_hi_cin",  32'(adder_cin), 32'h1);
        check("add_hi_a",    32'(adder_a),   32'h0);
        check("add_hi_done", 32'(done),      32'h0);
        step();                       // DONE
        check("add_done",    32'(done),   32'h1);
        check("add_busy",    32'(busy),   32'h0);
        check("add_result",  result,      32'h0001_0000);
        check("add_cout",    32'(cout),   32'h0);
        check("add_ovf",     32'(ovf),    32'h0);
        check("done_adder_b", 32'(adder_b), 32'h0);
        step();                       // IDLE
        check("add_done_pulse", 32'(done), 32'h0);
        check("add_hold",       result,    32'h0001_0000);

        // 0 - 1: borrow
        start = 1'b1; op = 1'b1; a = 32'h0; b = 32'h1;
        step(); start = 1'b0;
        check("sub0_lo_b",   32'(adder_b),   32'h0000_FFFE);
        check("sub0_lo_cin", 32'(adder_cin), 32'h1);
        step(); step();
        check("sub0_done",   32'(done), 32'h1);
        check("sub0_result", result,    32'hFFFF_FFFF);
        check("sub0_cout",   32'(cout), 32'h0);
        check("sub0_ovf",    32'(ovf),  32'h0);
        step();

        // 5 - 3: no borrow
        start = 1'b1; op = 1'b1; a = 32'd5; b = 32'd3;
        step(); start = 1'b0;
        step(); step();
        check("sub53_result", result,    32'd2);
        check("sub53_cout",   32'(cout), 32'h1);
        check("sub53_ovf",    32'(ovf),  32'h0);
        step();

        // 0x7FFFFFFF + 1: positive overflow
        start = 1'b1; op = 1'b0; a = 32'h7FFF_FFFF; b = 32'h1;
        step(); start = 1'b0;
        step(); step();
`ifdef ADDSUB_SAT_EN
        check("ovfp_result", result, 32'h7FFF_FFFF);
`else
        check("ovfp_result", result, 32'h8000_0000);
`endif
        check("ovfp_ovf",  32'(ovf),  32'h1);
        check("ovfp_cout", 32'(cout), 32'h0);
        step();

        // 0x80000000 + 0x80000000: negative overflow
        start = 1'b1; op = 1'b0; a = 32'h8000_0000; b = 32'h8000_0000;
        step(); start = 1'b0;
        step(); step();
`ifdef ADDSUB_SAT_EN
        check("ovfn_result", result, 32'h8000_0000);
`else
        check("ovfn_result", result, 32'h0000_0000);
`endif
        check("ovfn_ovf",  32'(ovf),  32'h1);
        check("ovfn_cout", 32'(cout), 32'h1);
        step();

        // Back-to-back: start held high. 1+2 is accepted, and the 10-4 request
        // presented during LO/HI is taken only in DONE.
        start = 1'b1; op = 1'b0; a = 32'd1; b = 32'd2;
        step();                       // LO (op 1)
        op = 1'b1; a = 32'd10; b = 32'd4;
        check("b2b_lo_a", 32'(adder_a), 32'h1);
        step();                       // HI (start ignored)
        check("b2b_hi_busy", 32'(busy), 32'h1);
        check("b2b_hi_a",    32'(adder_a), 32'h0);
        step();                       // DONE (op 1), accepts op 2
        check("b2b_done1",   32'(done), 32'h1);
        check("b2b_result1", result,    32'd3);
        step();                       // LO (op 2)
        start = 1'b0;
        check("b2b_lo2_busy", 32'(busy),    32'h1);
        check("b2b_lo2_done", 32'(done),    32'h0);
        check("b2b_lo2_a",    32'(adder_a), 32'd10);
        check("b2b_lo2_b",    32'(adder_b), 32'h0000_FFFB);
        step();                       // HI
        check("b2b_hi2_done", 32'(done), 32'h0);
        step();                       // DONE (op 2), 3 cycles after first
        check("b2b_done2",   32'(done), 32'h1);
        check("b2b_result2", result,    32'd6);
        check("b2b_cout2",   32'(cout), 32'h1);
        step();
        check("b2b_idle_busy", 32'(busy), 32'h0);
        check("b2b_idle_done", 32'(done), 32'h0);

        // Reset during HI: operation abandoned, no done afterwards
        start = 1'b1; op = 1'b0; a = 32'h1234_5678; b = 32'h1111_1111;
        step(); start = 1'b0;
        step();                       // HI
        check("rmid_hi_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rmid_busy",   32'(busy), 32'h0);
        check("rmid_done",   32'(done), 32'h0);
        check("rmid_result", result,    32'h0);
        check("rmid_cout",   32'(cout), 32'h0);
        check("rmid_ovf",    32'(ovf),  32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("rmid_no_done", 32'(done), 32'h0);
            check("rmid_no_busy", 32'(busy), 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
